// File: rtl/fp_divider_pkg.sv
// Shared definitions for the fp_divider slice: IEEE-754 constants, FSM states
// and field-extraction helpers.
package fp_divider_pkg;

    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [7:0]  FP_EXP_MIN = 8'h00;
    localparam logic [31:0] FP_INVALID = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_FIN   = 2'd3
    } fp_state_e;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Zero/denormal and inf/NaN exponents are not handled by the datapath.
    function automatic logic fp_is_special(input logic [31:0] x);
        return (fp_exp(x) == FP_EXP_MIN) || (fp_exp(x) == FP_EXP_MAX);
    endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Start/done operand interface shared by the fp_divider and its drivers.
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        overflow;
    logic        done;
    logic        busy;

    modport master (output start, a, b, input c, overflow, done, busy);
    modport slave  (input start, a, b, output c, overflow, done, busy);
endinterface

// File: rtl/fp_divider_mant_divider.sv
// Iterative radix-2 restoring significand divider, one quotient bit per step.
// With FP_DIV_STICKY_EN defined it also reports a nonzero final remainder.
module fp_mant_divider #(
    parameter int MANT_W = 24,
    parameter int QBITS  = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [QBITS-1:0]  quotient,
`ifdef FP_DIV_STICKY_EN
    output logic              rem_nz,
`endif
    output logic              last
);
    localparam int CNT_W = $clog2(QBITS);

    logic [MANT_W:0]   rem_r;
    logic [MANT_W-1:0] div_r;
    logic [QBITS-1:0]  q_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ge_s;
    logic [MANT_W-1:0] diff_s;
    logic [MANT_W-1:0] keep_s;

    // Trial subtraction; a kept remainder is always below the divisor, so MANT_W bits suffice.
    always_comb begin
        ge_s   = (rem_r >= {1'b0, div_r});
        diff_s = rem_r[MANT_W-1:0] - div_r;
        if (ge_s) begin
            keep_s = diff_s;
        end else begin
            keep_s = rem_r[MANT_W-1:0];
        end
    end

    // Remainder, divisor, quotient and bit-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r <= '0;
            div_r <= '0;
            q_r   <= '0;
            cnt_r <= '0;
        end else if (load) begin
            rem_r <= {1'b0, dividend};
            div_r <= divisor;
            q_r   <= '0;
            cnt_r <= CNT_W'(QBITS - 1);
        end else if (step) begin
            rem_r <= {keep_s, 1'b0};
            q_r   <= {q_r[QBITS-2:0], ge_s};
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            rem_r <= rem_r;
        end
    end

    assign quotient = q_r;
    assign last     = (cnt_r == '0);
`ifdef FP_DIV_STICKY_EN
    assign rem_nz   = |rem_r;
`endif

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider with start/done handshake.
// FP_DIV_STICKY_EN selects round-to-nearest-even; otherwise round-half-up.
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int QBITS  = 26
) (
    input logic         clk,
    input logic         reset,
    fp_divider_if.slave bus
);
    fp_state_e         state_r, state_nxt_s;
    logic              sign_r;
    logic [7:0]        ea_r, eb_r;
    logic [31:0]       res_r, c_r;
    logic              res_ovf_r, ovf_r, done_r, busy_r;
    logic              load_s, step_s, special_s, last_s;
    logic [QBITS-1:0]  q_s;
    logic [MANT_W-1:0] sig_pre_s;
    logic [MANT_W:0]   sum_s;
    logic [MANT_W-2:0] frac_s;
    logic              rnd_s, inc_s, round_ovf_s;
    logic signed [9:0] adj_pre_s, adj_s, exp_s;
    logic [31:0]       round_c_s;
`ifdef FP_DIV_STICKY_EN
    logic              rem_nz_s, sticky_s;
`endif

    assign special_s = fp_is_special(bus.a) | fp_is_special(bus.b);

    fp_mant_divider #(.MANT_W(MANT_W), .QBITS(QBITS)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .step     (step_s),
        .dividend ({1'b1, fp_frac(bus.a)}),
        .divisor  ({1'b1, fp_frac(bus.b)}),
        .quotient (q_s),
`ifdef FP_DIV_STICKY_EN
        .rem_nz   (rem_nz_s),
`endif
        .last     (last_s)
    );

    // Next-state and core control.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && special_s) begin
                    state_nxt_s = ST_FIN;
                end else if (bus.start) begin
                    state_nxt_s = ST_DIV;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_ROUND: state_nxt_s = ST_FIN;
            ST_FIN:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Normalise, round and form the exponent from the finished quotient.
    always_comb begin
        if (q_s[QBITS-1]) begin
            sig_pre_s = q_s[QBITS-1 -: MANT_W];
            rnd_s     = q_s[QBITS-1-MANT_W];
            adj_pre_s = 10'sd0;
        end else begin
            sig_pre_s = q_s[QBITS-2 -: MANT_W];
            rnd_s     = q_s[QBITS-2-MANT_W];
            adj_pre_s = -10'sd1;
        end
`ifdef FP_DIV_STICKY_EN
        if (q_s[QBITS-1]) begin
            sticky_s = rem_nz_s | q_s[0];
        end else begin
            sticky_s = rem_nz_s;
        end
        inc_s = rnd_s & (sticky_s | sig_pre_s[0]);
`else
        inc_s = rnd_s;
`endif
        sum_s = {1'b0, sig_pre_s} + {{MANT_W{1'b0}}, inc_s};
        if (sum_s[MANT_W]) begin
            frac_s = sum_s[MANT_W-1:1];
            adj_s  = adj_pre_s + 10'sd1;
        end else begin
            frac_s = sum_s[MANT_W-2:0];
            adj_s  = adj_pre_s;
        end
        exp_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
              + $signed(10'(FP_BIAS)) + adj_s;
        if ((exp_s <= 10'sd0) || (exp_s >= 10'sd255)) begin
            round_c_s   = FP_INVALID;
            round_ovf_s = 1'b1;
        end else begin
            round_c_s   = {sign_r, exp_s[7:0], frac_s};
            round_ovf_s = 1'b0;
        end
    end

    // State, operand fields, staged result and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            sign_r    <= 1'b0;
            ea_r      <= 8'h00;
            eb_r      <= 8'h00;
            res_r     <= 32'h0000_0000;
            res_ovf_r <= 1'b0;
            c_r       <= 32'h0000_0000;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sign_r    <= fp_sign(bus.a) ^ fp_sign(bus.b);
                        ea_r      <= fp_exp(bus.a);
                        eb_r      <= fp_exp(bus.b);
                        res_r     <= FP_INVALID;
                        res_ovf_r <= 1'b1;
                    end else begin
                        res_r     <= res_r;
                    end
                end
                ST_ROUND: begin
                    done_r    <= 1'b0;
                    res_r     <= round_c_s;
                    res_ovf_r <= round_ovf_s;
                end
                ST_FIN: begin
                    done_r <= 1'b1;
                    c_r    <= res_r;
                    ovf_r  <= res_ovf_r;
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign bus.c        = c_r;
    assign bus.overflow = ovf_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases, randomized operands
// against an integer-division reference model, reset abort and back-to-back.
module tb_fp_divider;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fp_divider_if bus ();

    fp_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer quotient of the significands, then rounding rules.
    function automatic logic [32:0] model_div(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ma, mb, num, q, r, sig;
        int              e, adj;
        logic            rbit, inc;
`ifdef FP_DIV_STICKY_EN
        logic            sticky;
`endif
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF)
            return {1'b1, 32'hFFFF_FFFF};
        ma  = 64'(x[22:0]) + 64'd8388608;
        mb  = 64'(y[22:0]) + 64'd8388608;
        num = ma << 25;
        q   = num / mb;
        r   = num % mb;
        if (q >= 64'd33554432) begin
            sig = q >> 2;
            rbit = q[1];
            adj = 0;
`ifdef FP_DIV_STICKY_EN
            sticky = (r != 0) || q[0];
`endif
        end else begin
            sig = q >> 1;
            rbit = q[0];
            adj = -1;
`ifdef FP_DIV_STICKY_EN
            sticky = (r != 0);
`endif
        end
`ifdef FP_DIV_STICKY_EN
        inc = rbit & (sticky | sig[0]);
`else
        inc = rbit;
`endif
        sig = sig + 64'(inc);
        if (sig >= 64'd16777216) begin
            sig = sig >> 1;
            adj = adj + 1;
        end
        e = int'(x[30:23]) - int'(y[30:23]) + 127 + adj;
        if (e <= 0 || e >= 255)
            return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, x[31] ^ y[31], e[7:0], sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input int mode);
        logic [7:0] e;
        if (mode == 0)      e = 8'($urandom_range(100, 154));
        else if (mode == 1) e = 8'($urandom_range(0, 255));
        else                e = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    // Drive one operation; lat is the cycle count from accept to done (-1 on timeout).
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2,
                         output logic [31:0] oc, output logic oovf, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb2;
        @(posedge clk);
        lat = -1;
        oc  = 32'h0;
        oovf = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.start = 1'b0;
                bus.a     = $urandom();
                bus.b     = $urandom();
            end
            if (bus.done) begin
                lat  = k;
                oc   = bus.c;
                oovf = bus.overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.c !== 32'h0)      begin failures++; $display("FAIL reset_c got=%h exp=00000000", bus.c); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        if (bus.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] da[7]   = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h00000000,
                                 32'h3F800000, 32'h7F000000, 32'h00800000};
        logic [31:0] db[7]   = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h40000000,
                                 32'h7F800000, 32'h00800000, 32'h7F000000};
        logic [31:0] dc[7]   = '{32'h40400000, 32'h3EAAAAAB, 32'hC0800000, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        dovf[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int          dlat[7] = '{28, 28, 28, 1, 1, 28, 28};
        logic [31:0] oc;
        logic        oovf;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(da[i], db[i], oc, oovf, lat);
            checks += 3;
            if (oc !== dc[i])
                begin failures++; $display("FAIL directed_c[%0d] got=%h exp=%h", i, oc, dc[i]); end
            if (oovf !== dovf[i])
                begin failures++; $display("FAIL directed_ovf[%0d] got=%b exp=%b", i, oovf, dovf[i]); end
            if (lat != dlat[i])
                begin failures++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, dlat[i]); end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0)
                begin failures++; $display("FAIL directed_pulse[%0d] got=%b exp=0", i, bus.done); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, oc;
        logic        oovf;
        logic [32:0] exp_v;
        int          lat, m, elat;
        for (int i = 0; i < 60; i++) begin
            m  = $urandom_range(0, 9);
            ra = rand_fp((m < 7) ? 0 : ((m < 9) ? 1 : 2));
            m  = $urandom_range(0, 9);
            rb = rand_fp((m < 7) ? 0 : ((m < 9) ? 1 : 2));
            exp_v = model_div(ra, rb);
            elat  = (ra[30:23] == 8'h00 || ra[30:23] == 8'hFF ||
                     rb[30:23] == 8'h00 || rb[30:23] == 8'hFF) ? 1 : 28;
            do_op(ra, rb, oc, oovf, lat);
            checks += 2;
            if ({oovf, oc} !== exp_v)
                begin failures++; $display("FAIL random[%0d] a=%h b=%h got=%b/%h exp=%b/%h",
                                           i, ra, rb, oovf, oc, exp_v[32], exp_v[31:0]); end
            if (lat != elat)
                begin failures++; $display("FAIL random_lat[%0d] got=%0d exp=%0d", i, lat, elat); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] oc;
        logic        oovf;
        int          lat, seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (bus.c !== 32'h0)   begin failures++; $display("FAIL abort_c got=%h exp=00000000", bus.c); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        do_op(32'h40C00000, 32'h40000000, oc, oovf, lat);
        checks += 2;
        if (oc !== 32'h40400000) begin failures++; $display("FAIL after_abort_c got=%h exp=40400000", oc); end
        if (lat != 28)           begin failures++; $display("FAIL after_abort_lat got=%0d exp=28", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[3], pb[3];
        logic [32:0] exp_v;
        int          ndone, last_cyc;
        for (int i = 0; i < 3; i++) begin
            pa[i] = rand_fp(0);
            pb[i] = rand_fp(0);
        end
        ndone    = 0;
        last_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = pa[0];
        bus.b     = pb[0];
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                if (ndone < 3) begin
                    exp_v = model_div(pa[ndone], pb[ndone]);
                    checks++;
                    if ({bus.overflow, bus.c} !== exp_v)
                        begin failures++; $display("FAIL b2b_c[%0d] got=%b/%h exp=%b/%h", ndone,
                                                   bus.overflow, bus.c, exp_v[32], exp_v[31:0]); end
                end
                if (ndone > 0) begin
                    checks++;
                    if (cyc - last_cyc != 29)
                        begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=29", ndone, cyc - last_cyc); end
                end
                last_cyc = cyc;
                ndone++;
                if (ndone < 3) begin
                    bus.a = pa[ndone];
                    bus.b = pb[ndone];
                end else begin
                    bus.start = 1'b0;
                end
            end else if (bus.busy) begin
                bus.a = $urandom();
                bus.b = $urandom();
            end
        end
        checks++;
        if (ndone != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
